// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: operation codes, FSM states and the
// shift-amount width helper.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0011,
        OP_SLL   = 4'b0100,
        OP_SRL   = 4'b0101,
        OP_SRA   = 4'b0111,
        OP_EQ    = 4'b1000,
        OP_XOR   = 4'b1001,
        OP_PASSB = 4'b1010,
        OP_SLT   = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic int shamt_w(input int data_width);
        return $clog2(data_width);
    endfunction

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit combinational shift: SLL fills 0, SRL fills 0, SRA replicates the sign.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [3:0]            op,
    output logic [DATA_WIDTH-1:0] dout
);

    always_comb begin
        case (op)
            OP_SLL:  dout = {din[DATA_WIDTH-2:0], 1'b0};
            OP_SRA:  dout = {din[DATA_WIDTH-1], din[DATA_WIDTH-1:1]};
            default: dout = {1'b0, din[DATA_WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/alu_iterative.sv
// Multi-cycle execute unit: single-cycle ALU ops plus one-bit-per-cycle shifts.
// Define ALU_ITER_FAST_SHIFT_EN to replace iterative shifting with a barrel shifter.
module alu_iterative
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  kill,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  Illegal,
    output alu_state_e            dbg_state
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready
    // && !kill; a result transfers where out_valid && out_ready. Only one op is
    // ever in flight, and the result holds still while out_ready is low.
    localparam int SHAMT_W = shamt_w(DATA_WIDTH);

    alu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] comb_res;
    logic                  comb_illegal;
    logic [SHAMT_W-1:0]    shamt;

    assign shamt = SrcB[SHAMT_W-1:0];

`ifndef ALU_ITER_FAST_SHIFT_EN
    logic [DATA_WIDTH-1:0] work_q, work_d, step_out;
    logic [SHAMT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]            shop_q, shop_d;

    alu_shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .din  (work_q),
        .op   (shop_q),
        .dout (step_out)
    );
`endif

    always_comb begin
        comb_res     = '0;
        comb_illegal = 1'b0;
        case (Operation)
            OP_AND:   comb_res = SrcA & SrcB;
            OP_OR:    comb_res = SrcA | SrcB;
            OP_ADD:   comb_res = SrcA + SrcB;
            OP_SUB:   comb_res = SrcA - SrcB;
            OP_XOR:   comb_res = SrcA ^ SrcB;
            OP_EQ:    comb_res = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
            OP_PASSB: comb_res = SrcB;
            OP_SLT:   comb_res = {{(DATA_WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
`ifdef ALU_ITER_FAST_SHIFT_EN
            OP_SLL:   comb_res = SrcA << shamt;
            OP_SRL:   comb_res = SrcA >> shamt;
            OP_SRA:   comb_res = $signed(SrcA) >>> shamt;
`else
            // Only reached with a zero amount; non-zero amounts go through SHIFT.
            OP_SLL, OP_SRL, OP_SRA: comb_res = SrcA;
`endif
            default:  comb_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifndef ALU_ITER_FAST_SHIFT_EN
        work_d    = work_q;
        cnt_d     = cnt_q;
        shop_d    = shop_q;
`endif
        if (kill) begin
            state_d = ST_IDLE;
`ifndef ALU_ITER_FAST_SHIFT_EN
            cnt_d   = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
`ifndef ALU_ITER_FAST_SHIFT_EN
                        if (is_shift_op(Operation) && (shamt != '0)) begin
                            work_d  = SrcA;
                            cnt_d   = shamt;
                            shop_d  = Operation;
                            state_d = ST_SHIFT;
                        end else
`endif
                        begin
                            result_d  = comb_res;
                            zero_d    = (comb_res == '0);
                            illegal_d = comb_illegal;
                            state_d   = ST_DONE;
                        end
                    end
                end
`ifndef ALU_ITER_FAST_SHIFT_EN
                ST_SHIFT: begin
                    work_d = step_out;
                    cnt_d  = cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_d  = step_out;
                        zero_d    = (step_out == '0);
                        illegal_d = 1'b0;
                        state_d   = ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
`ifndef ALU_ITER_FAST_SHIFT_EN
            work_q    <= '0;
            cnt_q     <= '0;
            shop_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifndef ALU_ITER_FAST_SHIFT_EN
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            shop_q    <= shop_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Illegal   = illegal_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: directed cases with literal results,
// then randomized ops, back-pressure and kills against a behavioural model.
module tb_alu_iterative;

    localparam int W = 32;
`ifdef ALU_ITER_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         kill = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, zero, illegal;
    logic [W-1:0] res;
    alu_pkg::alu_state_e dbg_state;

    int n_vec = 0;
    int n_fail = 0;
    bit rand_mode = 1'b0;

    logic [W+1:0] exp_q[$];
    bit busy = 1'b0;
    int cyc = 0;
    int lat = 0;

    alu_iterative #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (op),
        .SrcA      (a),
        .SrcB      (b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (res),
        .Zero      (zero),
        .Illegal   (illegal),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Expected {Illegal, Zero, ALUResult} straight from the operation table.
    function automatic logic [W+1:0] model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic ill;
        int sh;
        r = '0;
        ill = 1'b0;
        sh = int'(y[4:0]);
        case (o)
            4'h0: r = x & y;
            4'h1: r = x | y;
            4'h2: r = x + y;
            4'h3: r = x - y;
            4'h4: r = x << sh;
            4'h5: r = x >> sh;
            4'h7: r = $signed(x) >>> sh;
            4'h8: r = (x == y) ? 1 : 0;
            4'h9: r = x ^ y;
            4'hA: r = y;
            4'hC: r = ($signed(x) < $signed(y)) ? 1 : 0;
            default: ill = 1'b1;
        endcase
        return {ill, r == 0, r};
    endfunction

    function automatic int model_lat(input logic [3:0] o, input logic [W-1:0] y);
        if (!FAST && (o == 4'h4 || o == 4'h5 || o == 4'h7)) return int'(y[4:0]) + 1;
        return 1;
    endfunction

    task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: one op in flight, result valid lat cycles after accept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 1'b0;
            cyc = 0;
            exp_q.delete();
        end else if (kill) begin
            busy = 1'b0;
            exp_q.delete();
        end else if (!busy) begin
            if (in_valid) begin
                busy = 1'b1;
                cyc = 1;
                lat = model_lat(op, b);
                exp_q.push_back(model(op, a, b));
            end
        end else if (cyc >= lat) begin
            if (out_ready) begin
                busy = 1'b0;
                void'(exp_q.pop_front());
            end
        end else begin
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", {33'd0, in_ready}, {33'd0, !busy});
            chk("out_valid", {33'd0, out_valid}, {33'd0, busy && (cyc >= lat)});
            if (busy && (cyc >= lat) && (exp_q.size() > 0))
                chk("result", {illegal, zero, res}, exp_q[0]);
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
            kill = ($urandom_range(0, 49) == 0);
        end
    endtask

    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, need 1", in_ready, n);
        end
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_dir(input string name, input logic [3:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] exp_r,
                           input logic exp_ill, input int exp_lat);
        int n = 1;
        send(o, x, y);
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_lat"}, (W+2)'(n), (W+2)'(exp_lat));
        chk({name, "_res"}, {2'b00, res}, {2'b00, exp_r});
        chk({name, "_zero"}, {33'd0, zero}, {33'd0, exp_r == '0});
        chk({name, "_illegal"}, {33'd0, illegal}, {33'd0, exp_ill});
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, need finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] o;
        logic [W-1:0] x, y;
        int n;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {33'd0, in_ready}, {33'd0, 1'b1});
        chk("rst_out_valid", {33'd0, out_valid}, 34'd0);
        chk("rst_result", {illegal, zero, res}, {2'b01, 32'h0});
        rst_n = 1'b1;
        tick();

        run_dir("add", 4'h2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1);
        run_dir("sub", 4'h3, 32'd5, 32'd5, 32'h0, 1'b0, 1);
        run_dir("sra31", 4'h7, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, FAST ? 1 : 32);
        run_dir("srl31", 4'h5, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, FAST ? 1 : 32);
        run_dir("sll0", 4'h4, 32'h1, 32'd0, 32'h1, 1'b0, 1);
        run_dir("srl1", 4'h5, 32'h1, 32'h20 | 32'd1, 32'h0, 1'b0, FAST ? 1 : 2);
        run_dir("slt", 4'hC, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1);
        run_dir("eq", 4'h8, 32'h1234, 32'h1234, 32'h1, 1'b0, 1);
        run_dir("passb", 4'hA, 32'h5555, 32'hABCD_0000, 32'hABCD_0000, 1'b0, 1);
        run_dir("illegal", 4'hF, 32'h1234, 32'h5678, 32'h0, 1'b1, 1);

        // Back-pressure: result held for five cycles, then released.
        out_ready = 1'b0;
        send(4'h2, 32'd3, 32'd4);
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        repeat (5) begin
            tick();
            chk("hold_valid", {33'd0, out_valid}, {33'd0, 1'b1});
            chk("hold_res", {illegal, zero, res}, {2'b00, 32'd7});
            chk("hold_in_ready", {33'd0, in_ready}, 34'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("release_in_ready", {33'd0, in_ready}, {33'd0, 1'b1});
        chk("release_valid", {33'd0, out_valid}, 34'd0);

        // Kill during a 20-bit SLL.
        out_ready = 1'b0;
        send(4'h4, 32'h1, 32'd20);
        tick();
        if (!FAST) chk("prekill_valid", {33'd0, out_valid}, 34'd0);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_in_ready", {33'd0, in_ready}, {33'd0, 1'b1});
        chk("kill_valid", {33'd0, out_valid}, 34'd0);
        repeat (25) begin
            tick();
            chk("postkill_valid", {33'd0, out_valid}, 34'd0);
        end
        out_ready = 1'b1;

        // Asynchronous reset in the middle of a long shift.
        out_ready = 1'b0;
        send(4'h7, 32'h8000_0000, 32'd31);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {33'd0, in_ready}, {33'd0, 1'b1});
        chk("arst_valid", {33'd0, out_valid}, 34'd0);
        chk("arst_result", {illegal, zero, res}, {2'b01, 32'h0});
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // Randomized ops with random back-pressure and occasional kills.
        rand_mode = 1'b1;
        repeat (400) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 4) == 0) y = x;
            if ((o == 4'h4 || o == 4'h5 || o == 4'h7) && $urandom_range(0, 1) == 1)
                y = W'($urandom_range(0, 3));
            send(o, x, y);
        end
        rand_mode = 1'b0;
        kill = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
